// File: rtl/past_query_arbiter.sv
// Shared enable-gated history of one vector, like $past(x, N, en), that several
// requesters query through a round-robin arbiter with a registered one-cycle lookup.
module past_query_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int NREQ  = 3,
  localparam int DW   = $clog2(DEPTH) + 1,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic [WIDTH-1:0]   sample_in,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_depth,
  output logic [NREQ-1:0]    gnt,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic               rsp_hit,
  output logic [WIDTH-1:0]   rsp_data
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: req[i] is a level held until gnt[i] (combinational, one-hot)
  // is seen in the same cycle; the query is taken on that edge and answered by
  // a one-cycle rsp_valid strobe carrying rsp_id=i on the following cycle.

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [DW-1:0]    fill_q, fill_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic             rsp_valid_q, rsp_hit_q;
  logic [IW-1:0]    rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic [IW-1:0]    cand;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [DW-1:0]    n;
  logic             hit;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst) gnt_any = 1'b0;
  end

  assign gnt  = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign rr_d = IW'((int'(gnt_idx) + 1) % NREQ);

  // Lookup sees pre-edge wp/fill/mem, so a same-edge capture is not visible yet.
  assign n       = req_depth[int'(gnt_idx)*DW +: DW];
  assign hit     = (n != '0) && (n <= fill_q);
  assign rd_addr = wp_q - n[AW-1:0];
  assign rd_data = mem_q[rd_addr];
  assign fill_d  = (fill_q == DW'(DEPTH)) ? fill_q : fill_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst && sample_en) mem_q[wp_q] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= '0;
      fill_q      <= '0;
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (sample_en) begin
        wp_q   <= wp_q + 1'b1;
        fill_q <= fill_d;
      end
      rsp_valid_q <= gnt_any;
      if (gnt_any) begin
        rr_q       <= rr_d;
        rsp_id_q   <= gnt_idx;
        rsp_hit_q  <= hit;
        rsp_data_q <= hit ? rd_data : '0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_past_query_arbiter.sv
// Directed bench for past_query_arbiter: capture, gating, wrap, round-robin,
// same-edge capture and reset during a grant.
module tb_past_query_arbiter;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int NREQ  = 3;
  localparam int DW    = $clog2(DEPTH) + 1;
  localparam int IW    = $clog2(NREQ);

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_en;
  logic [WIDTH-1:0]   sample_in;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_depth;
  logic [NREQ-1:0]    gnt;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic               rsp_hit;
  logic [WIDTH-1:0]   rsp_data;

  int tests = 0;
  int fails = 0;

  past_query_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sample_in(sample_in),
    .req(req), .req_depth(req_depth), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_hit(rsp_hit), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [WIDTH-1:0] v);
    sample_en = 1'b1;
    sample_in = v;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Single-requester query; sample_en/sample_in are left as the caller set them.
  task automatic query(input string tag, input int id, input int depth,
                       input logic exp_hit, input logic [WIDTH-1:0] exp_data);
    req_depth = '0;
    req_depth[id*DW +: DW] = DW'(depth);
    req = NREQ'(1) << id;
    #2;
    check({tag, " gnt"}, 32'(gnt), 32'(NREQ'(1) << id));
    tick();
    req = '0;
    check({tag, " valid"}, 32'(rsp_valid), 32'(1));
    check({tag, " id"},    32'(rsp_id),    32'(id));
    check({tag, " hit"},   32'(rsp_hit),   32'(exp_hit));
    check({tag, " data"},  32'(rsp_data),  32'(exp_data));
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; sample_in = '0; req = 3'b001; req_depth = '0;
    #2;
    check("gnt in reset", 32'(gnt), 32'(0));
    tick();
    req = '0;
    tick();
    rst = 1'b0;
    check("rst valid", 32'(rsp_valid), 32'(0));
    check("rst id",    32'(rsp_id),    32'(0));
    check("rst hit",   32'(rsp_hit),   32'(0));
    check("rst data",  32'(rsp_data),  32'(0));

    // Empty history misses.
    query("empty d1", 0, 1, 1'b0, 4'h0);

    // Three commits, then depth probes.
    commit(4'h1); commit(4'h2); commit(4'h3);
    query("d1", 0, 1, 1'b1, 4'h3);
    query("d3", 0, 3, 1'b1, 4'h1);
    query("d4 miss", 0, 4, 1'b0, 4'h0);
    query("d0 miss", 0, 0, 1'b0, 4'h0);
    tick();
    check("idle valid", 32'(rsp_valid), 32'(0));
    check("idle hold id", 32'(rsp_id), 32'(0));

    // Gated edges leave history untouched.
    sample_in = 4'hF; sample_en = 1'b0;
    tick(); tick();
    query("gate d1", 1, 1, 1'b1, 4'h3);
    query("gate d2", 2, 2, 1'b1, 4'h2);

    // Wrap-around with fill saturated.
    do_reset();
    for (int v = 0; v < 10; v++) commit(WIDTH'(v));
    query("wrap d1", 0, 1, 1'b1, 4'h9);
    query("wrap d8", 0, 8, 1'b1, 4'h2);
    query("wrap d9 miss", 0, 9, 1'b0, 4'h0);

    // Round-robin with all requesters held.
    do_reset();
    commit(4'h7);
    req_depth = {DW'(1), DW'(1), DW'(1)};
    req = 3'b111;
    #2; check("rr gnt0", 32'(gnt), 32'(3'b001)); tick();
    check("rr v0", 32'(rsp_valid), 32'(1)); check("rr id0", 32'(rsp_id), 32'(0));
    check("rr data0", 32'(rsp_data), 32'(7));
    #2; check("rr gnt1", 32'(gnt), 32'(3'b010)); tick();
    check("rr v1", 32'(rsp_valid), 32'(1)); check("rr id1", 32'(rsp_id), 32'(1));
    #2; check("rr gnt2", 32'(gnt), 32'(3'b100)); tick();
    check("rr v2", 32'(rsp_valid), 32'(1)); check("rr id2", 32'(rsp_id), 32'(2));
    #2; check("rr gnt3", 32'(gnt), 32'(3'b001)); tick();
    check("rr v3", 32'(rsp_valid), 32'(1)); check("rr id3", 32'(rsp_id), 32'(0));
    req = '0;
    tick();
    check("rr idle valid", 32'(rsp_valid), 32'(0));

    // Same-edge capture and grant: lookup sees the older sample.
    commit(4'h5);
    sample_en = 1'b1; sample_in = 4'hA;
    query("same edge", 0, 1, 1'b1, 4'h5);
    sample_en = 1'b0;
    query("after cap", 0, 1, 1'b1, 4'hA);

    // Reset in the grant cycle drops the query; the re-request misses.
    req_depth = '0; req_depth[0 +: DW] = DW'(1);
    req = 3'b001; rst = 1'b1;
    #2;
    check("rst gnt", 32'(gnt), 32'(0));
    tick();
    rst = 1'b0;
    check("rst drop valid", 32'(rsp_valid), 32'(0));
    query("post rst", 0, 1, 1'b0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/past_query_arbiter.md
Name: past_query_arbiter

Overview:
Shared sampled-history engine. It captures an enable-gated history of one monitored vector, like `$past(x, N, en)`. It arbitrates round-robin between several requesters that ask for the value N enabled samples back. Sits beside assertion/checker logic, so several checkers share one history buffer instead of each keeping its own delay line.

Parameters:
WIDTH, 4, bit width of monitored vector and returned data.
DEPTH, 8, number of history entries; power of two, >=2.
NREQ, 3, number of requesters, >=2.
DW, $clog2(DEPTH)+1, width of one depth field (derived, not overridden).
IW, $clog2(NREQ), width of response id (derived).

Ports:
clk  input  1  single clock, all state updates on posedge.
rst  input  1  synchronous reset, active-high.
sample_en  input  1  gating enable; a sample is committed only on edges where it is 1.
sample_in  input  WIDTH  monitored vector.
req  input  NREQ  per-requester query request, level, held until granted.
req_depth  input  NREQ*DW  per-requester depth N; slice i = bits [i*DW +: DW].
gnt  output  NREQ  one-hot grant, combinational in request cycle.
rsp_valid  output  1  response strobe, one cycle.
rsp_id  output  IW  index of the requester being answered.
rsp_hit  output  1  1 when the requested depth is available.
rsp_data  output  WIDTH  historic value; 0 on miss.

Behaviour:
- Reset (rst=1 at an edge):
  - Write pointer wp=0, fill=0, round-robin pointer rr=0.
  - rsp_valid=0, rsp_id=0, rsp_hit=0, rsp_data=0.
  - History RAM not cleared; fill=0 makes it unreadable.
  - gnt is forced to 0 while rst=1.
  - Reset mid-query: the granted request is dropped, no response next cycle, and the requester re-requests.
- Capture:
  - On an edge with rst=0 and sample_en=1: buf[wp]<=sample_in, wp<=(wp+1) mod DEPTH, fill<=min(fill+1, DEPTH).
  - sample_en=0: no state change to history.
- Arbitration (combinational):
  - Grant the first i with req[i]=1, searching rr, rr+1, ... mod NREQ.
  - At most one gnt bit set; gnt=0 when req=0.
  - On a grant edge: rr<=(granted index+1) mod NREQ. No grant: rr unchanged.
  - Requester deasserts req in the cycle after gnt unless it issues a new query.
- Lookup, registered, latency 1 (grant at cycle t, rsp_valid=1 at t+1):
  - N = granted slice of req_depth, sampled in the grant cycle.
  - Hit when 1<=N<=fill, evaluated on pre-edge state. Then rsp_data = buf[(wp-N) mod DEPTH], rsp_hit=1.
  - N=0 or N>fill: rsp_hit=0, rsp_data=0.
  - Depth 1 = most recently committed sample.
- Simultaneous capture and grant on the same edge: lookup uses pre-write wp/fill/buf (sampled-value semantics). The new sample is visible to queries granted from the next cycle on.
- Back-to-back: one grant per cycle sustained; rsp_valid may stay high on consecutive cycles with different rsp_id.
- No-grant cycle: rsp_valid<=0. rsp_id/rsp_hit/rsp_data keep their last value.
- Wrap-around: after more than DEPTH commits the oldest entry is overwritten; fill saturates at DEPTH. Depth DEPTH returns the oldest retained sample.
- Width rules:
  - wp is $clog2(DEPTH) bits; subtraction wraps naturally.
  - fill is DW bits to hold DEPTH.
  - N > DEPTH is a miss.

Test Plan:
1. Reset, then req=001, depth0=1 -> gnt=001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_hit=0, rsp_data=0.
2. Commit 1,2,3 (sample_en=1, three edges); query depth 1 -> data 3, hit 1; depth 3 -> data 1, hit 1; depth 4 -> hit 0, data 0; depth 0 -> hit 0.
3. Gating: after step 2, sample_in=F with sample_en=0 for 2 edges; depth 1 -> 3, depth 2 -> 2.
4. Wrap: from reset commit 0..9; depth 1 -> 9, depth 8 -> 2, depth 9 -> hit 0.
5. Arbitration: req=111 held four cycles, all depths 1 -> gnt 001,010,100,001; rsp_id 0,1,2,0 on consecutive cycles with rsp_valid continuously 1.
6. Same-edge capture: last committed 5; grant depth 1 while sample_in=A, sample_en=1 -> rsp_data=5; next query -> A. Then assert rst in a grant cycle -> rsp_valid=0 next cycle, a following depth-1 query misses.
